wt_dcache_mem_responder: RTL and testbench
==========================================

WT_DCACHE_MEM_RESPONDER -- requirements
Module: wt_dcache_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 64, store data / memory word width.
- LINE_WIDTH, 128, refill line width; fixed at 2*DATA_WIDTH.
- TID_WIDTH, 2, transaction ID width.
- LATENCY, 4, minimum cycles from accept to response; legal range 1..15.
- MEM_WORDS, 64, backing store depth in words; power of two.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, single clock; all state updates on its rising edge.
- rst_i, in, 1, synchronous active-high reset.
- req_valid_i, in, 1, request valid.
- req_ready_o, out, 1, request can be accepted.
- req_store_i, in, 1, 1 = word store, 0 = line load.
- req_tid_i, in, TID_WIDTH, transaction ID.
- req_addr_i, in, ADDR_WIDTH, byte address.
- req_data_i, in, DATA_WIDTH, store data.
- req_be_i, in, DATA_WIDTH/8, store byte enables.
- rtrn_valid_o, out, 1, response valid.
- rtrn_ready_i, in, 1, response consumed.
- rtrn_store_o, out, 1, response type; echoes the request type.
- rtrn_tid_o, out, TID_WIDTH, echoed transaction ID.
- rtrn_data_o, out, LINE_WIDTH, load line; zero for store acks.
- outstanding_o, out, TID_WIDTH+1, number of queued entries.
- err_dup_tid_o, out, 1, one-cycle pulse on a duplicate-TID accept.
REQ-003 The single clock SHALL be clk_i; reset SHALL be synchronous and active-high, named rst_i.

Function
REQ-004 An accept SHALL occur when req_valid_i and req_ready_o are both high; at most one accept per cycle.
REQ-005 req_ready_o SHALL equal (outstanding_o < 2**TID_WIDTH) and SHALL NOT depend on rtrn_ready_i or on a same-cycle pop.
REQ-006 The queue SHALL be an in-order FIFO of 2**TID_WIDTH entries; responses SHALL return in accept order.
REQ-007 Store accept: in the accept cycle, memory word addr[log2(MEM_WORDS)+2:3] SHALL be written byte-wise under req_be_i; an ack entry with zero data SHALL be enqueued.
REQ-008 Load accept: line index addr[log2(MEM_WORDS)+2:4] SHALL be snapshotted into the entry as {word[2i+1], word[2i]} using memory contents before that cycle's edge.
REQ-009 Address bits above the memory index SHALL be ignored (wrap-around); load bits [3:0] and store bits [2:0] SHALL be ignored.
REQ-010 Each entry SHALL hold a countdown loaded with LATENCY-1 at accept, decremented every cycle, saturating at 0.
REQ-011 Response FSM states:
- IDLE: rtrn_valid_o=0; go to WAIT when the queue is non-empty.
- WAIT: go to RESP when the head countdown reaches 0.
- RESP: rtrn_valid_o=1 with the head's fields held stable; on rtrn_ready_i, pop the head, then go to WAIT if entries remain else IDLE.
REQ-012 For a request accepted at cycle T into an empty queue with the FSM in IDLE, rtrn_valid_o SHALL first be high at cycle T+LATENCY.
REQ-013 Back-to-back responses: the next entry SHALL be valid in the cycle after a pop if its countdown is 0, giving one response per cycle at full throughput.
REQ-014 Simultaneous accept and pop SHALL leave outstanding_o unchanged; when the queue is full, the pop frees a slot visible from the next cycle.
REQ-015 An accept whose TID matches any queued entry SHALL still be accepted and SHALL pulse err_dup_tid_o high in the following cycle.
REQ-016 rtrn_tid_o, rtrn_store_o and rtrn_data_o SHALL be zero whenever rtrn_valid_o is 0.

Reset
REQ-017 While rst_i is high at a clock edge: the queue SHALL be emptied, the FSM forced to IDLE, all memory words cleared to 0, and all outputs driven to 0 except req_ready_o.
REQ-018 req_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-019 Reset asserted mid-response (RESP state) SHALL drop rtrn_valid_o in the next cycle with no pop side effects; in-flight entries are discarded.

Verification
REQ-020 Store then load: store addr=0x10, data=0x1122334455667788, be=0xFF, tid=1; then load addr=0x10, tid=2 -> ack with tid 1 at T+4; load response tid 2, data=0x...0000_0000_0000_0000_1122334455667788 (upper word 0).
REQ-021 Partial store: be=0x0F, data=0xAAAAAAAA_BBBBBBBB to a zeroed word -> subsequent load returns that word as 0x00000000_BBBBBBBB.
REQ-022 Full queue with rtrn_ready_i=0: accept 4 loads, tids 0..3 -> req_ready_o=0 and outstanding_o=4; release rtrn_ready_i -> tids 0,1,2,3 return on consecutive cycles.
REQ-023 Duplicate TID: two loads with tid=3 -> both are accepted; err_dup_tid_o pulses once, one cycle after the second accept.
REQ-024 Wrap-around: store to addr 0x208 with MEM_WORDS=64 -> a load of addr 0x000 returns the stored word in the upper half of the line.
REQ-025 Reset mid-operation: assert rst_i while RESP holds tid 2 -> next cycle rtrn_valid_o=0, outstanding_o=0, and memory reads back 0.

Source files
------------

// File: rtl/wt_dcache_mem_responder.sv
// Memory-side responder for a write-through dcache: byte-enabled word stores, two-word line
// loads, and in-order responses released no earlier than LATENCY cycles after accept.
module wt_dcache_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 128,
  parameter int TID_WIDTH  = 2,
  parameter int LATENCY    = 4,
  parameter int MEM_WORDS  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_store_i,
  input  logic [TID_WIDTH-1:0]    req_tid_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rtrn_valid_o,
  input  logic                    rtrn_ready_i,
  output logic                    rtrn_store_o,
  output logic [TID_WIDTH-1:0]    rtrn_tid_o,
  output logic [LINE_WIDTH-1:0]   rtrn_data_o,
  output logic [TID_WIDTH:0]      outstanding_o,
  output logic                    err_dup_tid_o
);
  localparam int         DEPTH    = 2**TID_WIDTH;
  localparam int         MEM_AW   = $clog2(MEM_WORDS);
  localparam int         BE_W     = DATA_WIDTH/8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_mem     [MEM_WORDS];
  logic                  r_q_store [DEPTH];
  logic [TID_WIDTH-1:0]  r_q_tid   [DEPTH];
  logic [LINE_WIDTH-1:0] r_q_data  [DEPTH];
  logic [3:0]            r_q_cnt   [DEPTH];
  logic [TID_WIDTH-1:0]  r_head;
  logic [TID_WIDTH-1:0]  r_tail;
  logic [TID_WIDTH:0]    r_count;
  logic                  r_rtrn_valid;
  logic                  r_rtrn_store;
  logic [TID_WIDTH-1:0]  r_rtrn_tid;
  logic [LINE_WIDTH-1:0] r_rtrn_data;
  logic                  r_err_dup;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_dup;
  logic [MEM_AW-1:0]     w_word_idx;
  logic [MEM_AW-2:0]     w_line_idx;
  logic [LINE_WIDTH-1:0] w_new_data;
  logic [TID_WIDTH:0]    w_count_next;
  logic [TID_WIDTH-1:0]  w_rel;
  logic [TID_WIDTH-1:0]  w_nh_idx;
  logic                  w_nh_store;
  logic [TID_WIDTH-1:0]  w_nh_tid;
  logic [LINE_WIDTH-1:0] w_nh_data;
  logic [3:0]            w_nh_cnt;
  logic                  w_unused_addr;

  function automatic logic [3:0] sat_dec(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  // Count never exceeds DEPTH, so its MSB alone marks a full queue.
  assign req_ready_o   = ~r_count[TID_WIDTH];
  assign w_accept      = req_valid_i && req_ready_o;
  assign w_pop         = (r_state == S_RESP) && rtrn_ready_i;
  assign w_word_idx    = req_addr_i[MEM_AW+2:3];
  assign w_line_idx    = req_addr_i[MEM_AW+2:4];
  assign w_new_data    = req_store_i ? '0
                         : {r_mem[{w_line_idx, 1'b1}], r_mem[{w_line_idx, 1'b0}]};
  assign w_unused_addr = ^{req_addr_i[ADDR_WIDTH-1:MEM_AW+3], req_addr_i[2:0]};

  always_comb begin
    w_dup = 1'b0;
    w_rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rel = TID_WIDTH'(i) - r_head;
      if (({1'b0, w_rel} < r_count) && (r_q_tid[i] == req_tid_i)) w_dup = 1'b1;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_pop)      w_count_next = r_count + (TID_WIDTH+1)'(1);
    else if (!w_accept && w_pop) w_count_next = r_count - (TID_WIDTH+1)'(1);
  end

  // Head entry as it will look after this edge, including an accept into an emptied queue.
  always_comb begin
    w_nh_idx   = w_pop ? r_head + TID_WIDTH'(1) : r_head;
    w_nh_store = r_q_store[w_nh_idx];
    w_nh_tid   = r_q_tid[w_nh_idx];
    w_nh_data  = r_q_data[w_nh_idx];
    w_nh_cnt   = sat_dec(r_q_cnt[w_nh_idx]);
    if (w_accept && (w_nh_idx == r_tail)) begin
      w_nh_store = req_store_i;
      w_nh_tid   = req_tid_i;
      w_nh_data  = w_new_data;
      w_nh_cnt   = CNT_INIT;
    end
  end

  // NOTE: the backing store must read back as zero after reset, so every word is cleared;
  // this keeps r_mem in flops rather than a reset-less RAM macro.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_accept && req_store_i) begin
      for (int b = 0; b < BE_W; b++)
        if (req_be_i[b]) r_mem[w_word_idx][8*b +: 8] <= req_data_i[8*b +: 8];
    end
  end

  // NOTE: queue payload carries no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) r_q_cnt[i] <= sat_dec(r_q_cnt[i]);
    if (w_accept) begin
      r_q_store[r_tail] <= req_store_i;
      r_q_tid[r_tail]   <= req_tid_i;
      r_q_data[r_tail]  <= w_new_data;
      r_q_cnt[r_tail]   <= CNT_INIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_err_dup <= 1'b0;
    end else begin
      if (w_accept) r_tail <= r_tail + TID_WIDTH'(1);
      if (w_pop)    r_head <= r_head + TID_WIDTH'(1);
      r_count   <= w_count_next;
      r_err_dup <= w_accept && w_dup;
    end
  end

  // RESP is entered once the post-edge head countdown is zero, so a lone entry responds
  // exactly LATENCY cycles after accept and a ready successor follows a pop immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_rtrn_valid <= 1'b0;
      r_rtrn_store <= 1'b0;
      r_rtrn_tid   <= '0;
      r_rtrn_data  <= '0;
    end else begin
      r_rtrn_valid <= 1'b0;
      r_rtrn_store <= 1'b0;
      r_rtrn_tid   <= '0;
      r_rtrn_data  <= '0;
      if (w_count_next == '0) begin
        r_state <= S_IDLE;
      end else if (w_nh_cnt != 4'd0) begin
        r_state <= S_WAIT;
      end else begin
        r_state      <= S_RESP;
        r_rtrn_valid <= 1'b1;
        r_rtrn_store <= w_nh_store;
        r_rtrn_tid   <= w_nh_tid;
        r_rtrn_data  <= w_nh_data;
      end
    end
  end

  assign rtrn_valid_o  = r_rtrn_valid;
  assign rtrn_store_o  = r_rtrn_store;
  assign rtrn_tid_o    = r_rtrn_tid;
  assign rtrn_data_o   = r_rtrn_data;
  assign outstanding_o = r_count;
  assign err_dup_tid_o = r_err_dup;
endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Self-checking bench for wt_dcache_mem_responder: directed scenarios plus random traffic,
// all scored every cycle against a transaction-level model (queue of entries + word array).
module tb_wt_dcache_mem_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_store_i = 1'b0;
  logic [1:0]   req_tid_i = '0;
  logic [31:0]  req_addr_i = '0;
  logic [63:0]  req_data_i = '0;
  logic [7:0]   req_be_i = '0;
  logic         rtrn_valid_o;
  logic         rtrn_ready_i = 1'b0;
  logic         rtrn_store_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic [2:0]   outstanding_o;
  logic         err_dup_tid_o;

  always #5 clk_i = ~clk_i;

  wt_dcache_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .LINE_WIDTH(128),
    .TID_WIDTH(2), .LATENCY(LAT), .MEM_WORDS(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_tid_i(req_tid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_be_i(req_be_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i), .rtrn_store_o(rtrn_store_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o),
    .outstanding_o(outstanding_o), .err_dup_tid_o(err_dup_tid_o)
  );

  // Reference model: an entry may respond once LAT cycles have passed since its accept
  // and it is at the front of the queue.
  typedef struct {
    logic         store;
    logic [1:0]   tid;
    logic [127:0] data;
    int           acc;
  } entry_t;

  entry_t      m_q[$];
  logic [63:0] m_mem [64];
  int          m_cyc = 0;
  bit          m_known = 0;
  logic        m_err = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // One clock cycle: drive, score outputs at the falling edge, advance the model past the rising edge.
  task automatic step(input logic rst, input logic v, input logic st, input logic [1:0] tid,
                      input logic [31:0] addr, input logic [63:0] d, input logic [7:0] be,
                      input logic rr);
    logic e_rdy, e_vld, e_st, acc, pop, dup;
    logic [1:0] e_tid;
    logic [127:0] e_data;
    logic [2:0] e_out;
    entry_t ne;
    int li, wi;
    rst_i = rst; req_valid_i = v; req_store_i = st; req_tid_i = tid;
    req_addr_i = addr; req_data_i = d; req_be_i = be; rtrn_ready_i = rr;
    @(negedge clk_i);
    e_rdy = (m_q.size() < DEPTH);
    e_vld = 1'b0; e_st = 1'b0; e_tid = '0; e_data = '0;
    if (m_q.size() > 0) begin
      if (m_cyc >= m_q[0].acc + LAT) begin
        e_vld = 1'b1; e_st = m_q[0].store; e_tid = m_q[0].tid; e_data = m_q[0].data;
      end
    end
    e_out = 3'(m_q.size());
    if (m_known) begin
      n_cmp++;
      if ({req_ready_o, rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o, outstanding_o, err_dup_tid_o}
          !== {e_rdy, e_vld, e_st, e_tid, e_data, e_out, m_err}) begin
        n_bad++;
        $display("FAIL model cyc=%0d: got rdy=%b vld=%b st=%b tid=%0d data=%h out=%0d dup=%b; want rdy=%b vld=%b st=%b tid=%0d data=%h out=%0d dup=%b",
                 m_cyc, req_ready_o, rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o, outstanding_o,
                 err_dup_tid_o, e_rdy, e_vld, e_st, e_tid, e_data, e_out, m_err);
      end
    end
    acc = v && e_rdy;
    pop = e_vld && rr;
    @(posedge clk_i);
    #1;
    if (rst) begin
      m_q.delete();
      foreach (m_mem[i]) m_mem[i] = '0;
      m_err = 1'b0;
      m_known = 1;
    end else begin
      dup = 1'b0;
      ne = '{store: st, tid: tid, data: '0, acc: m_cyc};
      if (acc) begin
        foreach (m_q[i]) if (m_q[i].tid == tid) dup = 1'b1;
        if (!st) begin
          li = int'(addr[8:4]);
          ne.data = {m_mem[2*li+1], m_mem[2*li]};
        end
      end
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(ne);
        if (st) begin
          wi = int'(addr[8:3]);
          for (int b = 0; b < 8; b++) if (be[b]) m_mem[wi][8*b +: 8] = d[8*b +: 8];
        end
      end
      m_err = dup;
    end
    m_cyc++;
  endtask

  task automatic drain();
    int k = 0;
    while (m_q.size() != 0 && k < 64) begin
      step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
      k++;
    end
    n_cmp++;
    if (m_q.size() != 0 || outstanding_o !== 3'd0) begin
      n_bad++;
      $display("FAIL drain: outstanding=%0d after %0d cycles, want 0", outstanding_o, k);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 0);
    step(1, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 0);
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
    n_cmp++;
    if ({rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o, outstanding_o, err_dup_tid_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: vld=%b st=%b tid=%0d data=%h out=%0d dup=%b want all 0",
               rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o, outstanding_o, err_dup_tid_o);
    end
  endtask

  task automatic test_store_load();
    step(0, 1, 1, 2'd1, 32'h10, 64'h1122334455667788, 8'hFF, 1);
    step(0, 1, 0, 2'd2, 32'h10, 64'h0, 8'h0, 1);
    step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    n_cmp++;
    if (rtrn_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL store_ack_early: valid=%b at T+3 want 0", rtrn_valid_o);
    end
    step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    n_cmp++;
    if ({rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o} !== {1'b1, 1'b1, 2'd1, 128'h0}) begin
      n_bad++;
      $display("FAIL store_ack: vld=%b st=%b tid=%0d data=%h want 1 1 1 0",
               rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o);
    end
    step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    n_cmp++;
    if ({rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o}
        !== {1'b1, 1'b0, 2'd2, 64'h0, 64'h1122334455667788}) begin
      n_bad++;
      $display("FAIL load_after_store: vld=%b st=%b tid=%0d data=%h want 1 0 2 %h",
               rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_data_o, {64'h0, 64'h1122334455667788});
    end
    drain();
  endtask

  task automatic test_partial_store();
    bit got = 0;
    step(0, 1, 1, 2'd0, 32'h40, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1);
    step(0, 1, 0, 2'd1, 32'h40, 64'h0, 8'h0, 1);
    for (int k = 0; k < 20 && !got; k++) begin
      if (rtrn_valid_o === 1'b1 && rtrn_store_o === 1'b0) begin
        got = 1; n_cmp++;
        if (rtrn_data_o !== {64'h0, 64'h00000000_BBBBBBBB}) begin
          n_bad++; $display("FAIL partial_store: data=%h want %h", rtrn_data_o, {64'h0, 64'h00000000_BBBBBBBB});
        end
      end
      step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    end
    if (!got) begin
      n_cmp++; n_bad++; $display("FAIL partial_store: no load response within 20 cycles");
    end
    drain();
  endtask

  task automatic test_full_queue();
    for (int t = 0; t < 4; t++) step(0, 1, 0, 2'(t), 32'(t * 16), 64'h0, 8'h0, 0);
    n_cmp++;
    if (req_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin
      n_bad++; $display("FAIL full_queue: ready=%b outstanding=%0d want 0 and 4", req_ready_o, outstanding_o);
    end
    repeat (4) step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 0);
    for (int t = 0; t < 4; t++) begin
      n_cmp++;
      if (rtrn_valid_o !== 1'b1 || rtrn_tid_o !== 2'(t)) begin
        n_bad++; $display("FAIL back_to_back[%0d]: vld=%b tid=%0d want 1 %0d", t, rtrn_valid_o, rtrn_tid_o, t);
      end
      step(0, 1, 0, 2'(t), 32'h100, 64'h0, 8'h0, 1);
      n_cmp++;
      if (outstanding_o !== 3'd3) begin
        n_bad++; $display("FAIL pop_accept[%0d]: outstanding=%0d want 3", t, outstanding_o);
      end
    end
    drain();
  endtask

  task automatic test_dup_tid();
    step(0, 1, 0, 2'd3, 32'h0, 64'h0, 8'h0, 0);
    n_cmp++;
    if (err_dup_tid_o !== 1'b0) begin
      n_bad++; $display("FAIL dup_first: err=%b want 0", err_dup_tid_o);
    end
    step(0, 1, 0, 2'd3, 32'h20, 64'h0, 8'h0, 0);
    n_cmp++;
    if (err_dup_tid_o !== 1'b1 || outstanding_o !== 3'd2) begin
      n_bad++; $display("FAIL dup_pulse: err=%b outstanding=%0d want 1 2", err_dup_tid_o, outstanding_o);
    end
    step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 0);
    n_cmp++;
    if (err_dup_tid_o !== 1'b0) begin
      n_bad++; $display("FAIL dup_width: err=%b want 0", err_dup_tid_o);
    end
    drain();
  endtask

  task automatic test_wrap();
    bit got = 0;
    step(0, 1, 1, 2'd2, 32'h208, 64'h0123456789ABCDEF, 8'hFF, 1);
    step(0, 1, 0, 2'd3, 32'h000, 64'h0, 8'h0, 1);
    for (int k = 0; k < 20 && !got; k++) begin
      if (rtrn_valid_o === 1'b1 && rtrn_store_o === 1'b0) begin
        got = 1; n_cmp++;
        if (rtrn_data_o !== {64'h0123456789ABCDEF, 64'h0}) begin
          n_bad++; $display("FAIL wrap: data=%h want %h", rtrn_data_o, {64'h0123456789ABCDEF, 64'h0});
        end
      end
      step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    end
    if (!got) begin
      n_cmp++; n_bad++; $display("FAIL wrap: no load response within 20 cycles");
    end
    drain();
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           32'($urandom), {32'($urandom), 32'($urandom)}, 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 9) < 5));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit got = 0;
    step(0, 1, 1, 2'd0, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1);
    drain();
    step(0, 1, 0, 2'd2, 32'h10, 64'h0, 8'h0, 0);
    for (int k = 0; k < 20 && !found; k++) begin
      if (rtrn_valid_o === 1'b1 && rtrn_tid_o === 2'd2) found = 1;
      else step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 0);
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL reset_mid_setup: tid 2 response not seen within 20 cycles");
    end
    step(1, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    n_cmp++;
    if (rtrn_valid_o !== 1'b0 || outstanding_o !== 3'd0 || req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: vld=%b outstanding=%0d ready=%b want 0 0 1", rtrn_valid_o, outstanding_o, req_ready_o);
    end
    step(0, 1, 0, 2'd1, 32'h10, 64'h0, 8'h0, 1);
    for (int k = 0; k < 20 && !got; k++) begin
      if (rtrn_valid_o === 1'b1) begin
        got = 1; n_cmp++;
        if (rtrn_data_o !== 128'h0 || rtrn_tid_o !== 2'd1) begin
          n_bad++; $display("FAIL reset_mem_clear: tid=%0d data=%h want 1 0", rtrn_tid_o, rtrn_data_o);
        end
      end
      step(0, 0, 0, 2'd0, 32'h0, 64'h0, 8'h0, 1);
    end
    if (!got) begin
      n_cmp++; n_bad++; $display("FAIL reset_mem_clear: no load response within 20 cycles");
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_full_queue();
    test_dup_tid();
    test_wrap();
    test_random(400);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
